// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: FSM encodings, status bit
// positions and the decoder addresses the two selects correspond to.
package uart_pkg;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_AVAIL = 2;
    localparam int ST_TX_BUSY  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_FRAME    = 5;
    localparam int ST_TX_OVF   = 6;

    localparam logic [1:0] UART_ADDR   = 2'd3;
    localparam logic [1:0] STATUS_ADDR = 2'd0;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A push is accepted while full
// only if a pop drains an entry in the same cycle; a pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, serialiser, deserialiser with a 2-flop
// input synchroniser, and a status word with write-1-to-clear sticky flags.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] dataIn,
    input  logic        write,
    input  logic        read,
    input  logic        uart_sel,
    input  logic        status_sel,
    output logic [15:0] dataOut,
    output logic        TX,
    input  logic        RX
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    tx_state_t        tx_state;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [2:0]       tx_bit, rx_bit;
    logic [7:0]       tx_shift, rx_shift, tx_head, rx_head;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             tx_push, tx_pop, rx_push, rx_pop, tx_busy;
    logic             rx_s1, rx_s2;
    logic             tx_ovf, rx_ovf, frame_err;
    logic             tx_ovf_set, rx_ovf_set, frame_set, sts_wr;
    logic [6:0]       status;
    logic             unused_din;

    assign unused_din = ^dataIn[15:8];

    assign tx_push    = uart_sel & write;
    assign rx_pop     = uart_sel & read;
    assign sts_wr     = status_sel & write;
    assign tx_pop     = (tx_state == TX_IDLE) && !tx_empty;
    assign tx_busy    = (tx_state != TX_IDLE);
    assign rx_push    = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
    assign frame_set  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_s2;
    // An overflow is a push the FIFO refused: full with no simultaneous drain.
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_ovf_set = rx_push && rx_full && !rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clk(CLK), .rst(RST), .push(tx_push), .pop(tx_pop), .din(dataIn[7:0]),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clk(CLK), .rst(RST), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    // TX is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            TX       <= 1'b1;
        end else begin
            TX <= (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
            unique case (tx_state)
                TX_IDLE: if (!tx_empty) begin
                    tx_shift <= tx_head;
                    tx_cnt   <= '0;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end else tx_cnt <= tx_cnt + 1'b1;
                TX_DATA: if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    else                tx_bit   <= tx_bit + 1'b1;
                end else tx_cnt <= tx_cnt + 1'b1;
                TX_STOP: if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_state <= TX_IDLE;
                end else tx_cnt <= tx_cnt + 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            case (rx_state)
                RX_IDLE: if (!rx_s2) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    else                rx_bit   <= rx_bit + 1'b1;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A set in the same cycle as its W1C clear wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_ovf    <= (tx_ovf    & ~(sts_wr & dataIn[ST_TX_OVF])) | tx_ovf_set;
            rx_ovf    <= (rx_ovf    & ~(sts_wr & dataIn[ST_RX_OVF])) | rx_ovf_set;
            frame_err <= (frame_err & ~(sts_wr & dataIn[ST_FRAME]))  | frame_set;
        end
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_RX_OVF]   = rx_ovf;
        status[ST_FRAME]    = frame_err;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        dataOut = '0;
        if (uart_sel) begin
            dataOut[15]  = rx_empty;
            dataOut[7:0] = rx_empty ? 8'h00 : rx_head;
        end else if (status_sel) begin
            dataOut[6:0] = status;
        end
    end
endmodule
